mem_arbiter: RTL and testbench



---
 rtl/holy_core_pkg.sv | 12 +
 rtl/mem_lane_align.sv | 26 ++
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/holy_core_pkg.sv
// holy_core_pkg: shared load/store encodings and memory-arbiter state/owner types.
package holy_core_pkg;
  typedef enum logic [2:0] {
    BYTE       = 3'b000,
    HALFWORD   = 3'b001,
    WORD       = 3'b010,
    BYTE_U     = 3'b100,
    HALFWORD_U = 3'b101
  } load_store_funct3_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} arb_state_t;
  typedef enum logic {OWNER_I, OWNER_D} arb_owner_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte enables, store lane replication, fault detect and load extension.
module mem_lane_align
  import holy_core_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        fault_o,
  output logic [31:0] rdata_o
);
  logic [1:0]  sz;
  logic [31:0] sh;
  always_comb begin
    sz = funct3_i[1:0];
    be_o = sz == 2'd0 ? 4'b0001 << addr_i : sz == 2'd1 ? 4'b0011 << addr_i : 4'b1111;
    wdata_o = sz == 2'd0 ? {4{wdata_i[7:0]}} : sz == 2'd1 ? {2{wdata_i[15:0]}} : wdata_i;
    fault_o = !(funct3_i inside {BYTE, HALFWORD, WORD, BYTE_U, HALFWORD_U}) ||
              (sz == 2'd1 && addr_i[0]) || (sz == 2'd2 && addr_i != 2'd0);
    sh = rdata_i >> {addr_i, 3'b000};
    rdata_o = sz == 2'd0 ? {{24{sh[7] & ~funct3_i[2]}}, sh[7:0]} :
              sz == 2'd1 ? {{16{sh[15] & ~funct3_i[2]}}, sh[15:0]} : sh;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and load/store, one transaction at a time.
// Define HOLY_ARB_ROUND_ROBIN_EN for round-robin on contention; default is fixed D-over-I priority.
module mem_arbiter
  import holy_core_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_addr,
  output logic        i_rsp_valid,
  output logic [31:0] i_rsp_data,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_err,
  output logic        m_req_valid,
  input  logic        m_req_ready,
  output logic [31:0] m_addr,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic        m_rsp_valid,
  input  logic [31:0] m_rsp_data
);
  arb_state_t  state_q, state_d;
  arb_owner_t  owner_q, owner_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic        idle, issue, pick_d, pick_i, grant, fire;
  logic [31:0] cur_addr, cur_wdata;
  logic [2:0]  cur_f3;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;
  logic        al_fault;

  // owner_q doubles as last_owner for the round-robin decision
  always_comb begin
    idle = state_q == IDLE;
`ifdef HOLY_ARB_ROUND_ROBIN_EN
    pick_d = idle && d_req_valid && (!i_req_valid || owner_q == OWNER_I);
`else
    pick_d = idle && d_req_valid;
`endif
    pick_i = idle && i_req_valid && !pick_d;
    grant = pick_d || pick_i;
    cur_f3 = pick_d ? d_funct3 : WORD;
    cur_addr = pick_d ? d_addr : i_addr & 32'hFFFF_FFFC;
    cur_wdata = pick_d ? d_wdata : '0;
  end

  // incoming request is decoded while idle, the captured one afterwards
  mem_lane_align u_align (
    .funct3_i(idle ? cur_f3 : f3_q),
    .addr_i  (idle ? cur_addr[1:0] : addr_q[1:0]),
    .wdata_i (cur_wdata),
    .rdata_i (m_rsp_data),
    .be_o    (al_be),
    .wdata_o (al_wdata),
    .fault_o (al_fault),
    .rdata_o (al_rdata)
  );

  always_comb begin
    issue = state_q == ISSUE;
    fire = state_q == WAIT && m_rsp_valid;
    state_d = idle ? (pick_d && al_fault ? ERR : grant ? ISSUE : IDLE) :
              issue ? (m_req_ready ? WAIT : ISSUE) :
              state_q == WAIT ? (m_rsp_valid ? IDLE : WAIT) : IDLE;
    owner_d = grant ? (pick_d ? OWNER_D : OWNER_I) : owner_q;
    addr_d = grant ? cur_addr : addr_q;
    f3_d = grant ? cur_f3 : f3_q;
    we_d = grant ? pick_d && d_we : we_q;
    be_d = grant ? al_be : be_q;
    wdata_d = grant ? al_wdata : wdata_q;
    i_req_ready = pick_i;
    d_req_ready = pick_d;
    m_req_valid = issue;
    m_addr = issue ? {addr_q[31:2], 2'b00} : '0;
    m_we = issue && we_q;
    m_be = issue ? be_q : '0;
    m_wdata = issue ? wdata_q : '0;
    i_rsp_valid = fire && owner_q == OWNER_I;
    i_rsp_data = i_rsp_valid ? m_rsp_data : '0;
    d_rsp_err = state_q == ERR;
    d_rsp_valid = (fire && owner_q == OWNER_D) || d_rsp_err;
    d_rsp_data = fire && owner_q == OWNER_D && !we_q ? al_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWNER_D;
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a spec-level model.
module tb_mem_arbiter;
  logic        clk = 0, rst_n = 0;
  logic        i_req_valid, i_req_ready, i_rsp_valid;
  logic [31:0] i_addr, i_rsp_data;
  logic        d_req_valid, d_req_ready, d_we, d_rsp_valid, d_rsp_err;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr, d_wdata, d_rsp_data;
  logic        m_req_valid, m_req_ready, m_we, m_rsp_valid;
  logic [31:0] m_addr, m_wdata, m_rsp_data;
  logic [3:0]  m_be;
  int          n_cmp = 0, n_err = 0;
  bit          last_d = 1;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_we(d_we), .d_funct3(d_funct3), .d_wdata(d_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_addr(m_addr),
    .m_we(m_we), .m_be(m_be), .m_wdata(m_wdata),
    .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit f_fault(logic [31:0] a, logic [2:0] f3);
    int nb = 1 << f3[1:0];
    return (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) || (a % nb != 0);
  endfunction

  function automatic logic [3:0] f_be(logic [31:0] a, logic [2:0] f3);
    int nb = 1 << f3[1:0];
    int m = ((1 << nb) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] f_wdata(logic [31:0] wd, logic [2:0] f3);
    int nb = 1 << f3[1:0];
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] f_load(logic [31:0] word, logic [31:0] a, logic [2:0] f3);
    int nb = 1 << f3[1:0];
    logic [31:0] v = word >> (8 * (a % 4));
    logic [31:0] mask = nb == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 1;
    v &= mask;
    if (!f3[2] && v[8*nb-1]) v |= ~mask;
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 0;
    {i_req_valid, d_req_valid, d_we, m_req_ready, m_rsp_valid} = '0;
    {i_addr, d_addr, d_wdata, m_rsp_data} = '0;
    d_funct3 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    last_d = 1;
  endtask

  // One full transaction starting in IDLE; got_d reports which side was granted.
  task automatic xact(input bit vi, input bit vd, input logic [31:0] ia, input logic [31:0] da,
                      input logic we, input logic [2:0] f3, input logic [31:0] wd,
                      input logic [31:0] word, input int stall, input int lat, output bit got_d);
    bit win_d, flt;
    i_req_valid = vi; i_addr = ia;
    d_req_valid = vd; d_addr = da; d_we = we; d_funct3 = f3; d_wdata = wd;
`ifdef HOLY_ARB_ROUND_ROBIN_EN
    win_d = vd && (!vi || !last_d);
`else
    win_d = vd;
`endif
    last_d = win_d;
    flt = win_d && f_fault(da, f3);
    @(negedge clk);
    got_d = d_req_ready;
    check("i_ready", i_req_ready, !win_d);
    check("d_ready", d_req_ready, win_d);
    @(posedge clk); #1;
    if (win_d) d_req_valid = 0; else i_req_valid = 0;
    if (flt) begin
      @(negedge clk);
      check("err_valid", d_rsp_valid, 1);
      check("err_flag", d_rsp_err, 1);
      check("err_data", d_rsp_data, 0);
      check("err_no_mreq", m_req_valid, 0);
      @(posedge clk); #1;
      return;
    end
    for (int s = 0; s <= stall; s++) begin
      m_req_ready = s == stall;
      m_rsp_valid = s < stall ? 1'($urandom_range(0, 1)) : 1'b0;
      m_rsp_data = $urandom;
      @(negedge clk);
      check("m_valid", m_req_valid, 1);
      check("busy_ready", i_req_ready | d_req_ready, 0);
      check("stray_rsp", i_rsp_valid | d_rsp_valid, 0);
      if (s == stall) begin
        check("m_addr", m_addr, (win_d ? da : ia) & 32'hFFFF_FFFC);
        check("m_we", m_we, win_d && we);
        check("m_be", m_be, win_d ? f_be(da, f3) : 4'hF);
        if (win_d && we) check("m_wdata", m_wdata, f_wdata(wd, f3));
      end
      @(posedge clk); #1;
    end
    m_req_ready = 0; m_rsp_valid = 0;
    for (int l = 0; l < lat; l++) begin
      @(negedge clk);
      check("wait_quiet", {m_req_valid, i_rsp_valid, d_rsp_valid}, 0);
      @(posedge clk); #1;
    end
    m_rsp_valid = 1; m_rsp_data = word;
    @(negedge clk);
    if (win_d) begin
      check("d_rsp_valid", d_rsp_valid, 1);
      check("d_rsp_data", d_rsp_data, we ? 32'h0 : f_load(word, da, f3));
      check("d_rsp_err", d_rsp_err, 0);
      check("i_rsp_idle", i_rsp_valid, 0);
    end else begin
      check("i_rsp_valid", i_rsp_valid, 1);
      check("i_rsp_data", i_rsp_data, word);
      check("d_rsp_idle", d_rsp_valid, 0);
    end
    @(posedge clk); #1;
    m_rsp_valid = 0;
  endtask

  initial begin
    bit g;
    logic [3:0] seq, exp_seq;
    do_reset();
    @(negedge clk);
    check("rst_state", {i_req_ready, d_req_ready, m_req_valid, i_rsp_valid, d_rsp_valid, d_rsp_err, m_we}, 0);
    check("rst_data", m_addr | m_wdata | i_rsp_data | d_rsp_data | {28'h0, m_be}, 0);
    @(posedge clk); #1;
    xact(1, 0, 32'h100, 0, 0, 3'b010, 0, 32'hDEAD_BEEF, 0, 0, g);
    xact(0, 1, 0, 32'h203, 0, 3'b000, 0, 32'h8011_2233, 0, 0, g);
    check("lb_val", f_load(32'h8011_2233, 32'h203, 3'b000), 32'hFFFF_FF80);
    xact(0, 1, 0, 32'h203, 0, 3'b100, 0, 32'h8011_2233, 1, 1, g);
    xact(0, 1, 0, 32'h202, 0, 3'b101, 0, 32'h8011_2233, 0, 2, g);
    xact(0, 1, 0, 32'h302, 1, 3'b001, 32'h0000_ABCD, 32'h1234_5678, 2, 0, g);
    xact(0, 1, 0, 32'h401, 0, 3'b010, 0, 0, 0, 0, g);
    xact(0, 1, 0, 32'h400, 0, 3'b011, 0, 0, 0, 0, g);
    do_reset();
    seq = 0;
    for (int k = 0; k < 4; k++) begin
      xact(1, 1, 32'h600 + 4 * k, 32'h700 + 4 * k, 0, 3'b010, 0, $urandom, 0, 0, g);
      seq[k] = g;
    end
`ifdef HOLY_ARB_ROUND_ROBIN_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b1111;
`endif
    check("arb_seq", seq, exp_seq);
    i_req_valid = 0; d_req_valid = 0;
    d_req_valid = 1; d_addr = 32'h500; d_funct3 = 3'b010; d_we = 0;
    @(posedge clk); #1;
    d_req_valid = 0; m_req_ready = 1;
    @(posedge clk); #1;
    m_req_ready = 0;
    rst_n = 0;
    #1;
    check("rst_mid", {i_req_ready, d_req_ready, m_req_valid, i_rsp_valid, d_rsp_valid, d_rsp_err, m_we}, 0);
    check("rst_mid_data", m_addr | m_wdata | {28'h0, m_be}, 0);
    @(posedge clk); #1;
    rst_n = 1; last_d = 1;
    m_rsp_valid = 1; m_rsp_data = 32'hBAD0_BAD0;
    @(negedge clk);
    check("stale_rsp", {i_rsp_valid, d_rsp_valid}, 0);
    @(posedge clk); #1;
    m_rsp_valid = 0;
    xact(1, 0, 32'h804, 0, 0, 3'b010, 0, 32'hCAFE_F00D, 0, 0, g);
    for (int n = 0; n < 60; n++) begin
      bit vi, vd;
      vi = 1'($urandom_range(0, 1));
      vd = !vi || 1'($urandom_range(0, 1));
      xact(vi, vd, $urandom, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), g);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
